// File: rtl/detector_jogada.sv
// Debounced player-move detector: filters the raw switch vector and reports a one-hot
// play (or rejects a multi-key press) once per press, then waits for a debounced release.
module detector_jogada #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] chaves,
  input  logic       habilita,
  output logic       jogada_feita,
  output logic [3:0] jogada,
  output logic       jogada_invalida,
  output logic [3:0] db_estado,
  output logic       db_tem_jogada
);

  localparam int unsigned W_CHAVES = 4;
  localparam int unsigned W_CNT    = 8;
  localparam int unsigned W_ESTADO = 4;
  localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    FILTRA   = 3'd1,
    PULSO    = 3'd2,
    INVALIDA = 3'd3,
    SOLTA    = 3'd4
  } estado_t;

  estado_t             r_estado;
  estado_t             w_prox;
  logic [W_CHAVES-1:0] r_amostra;
  logic [W_CHAVES-1:0] w_amostra;
  logic [W_CNT-1:0]    r_cnt;
  logic [W_CNT-1:0]    w_cnt;
  logic [W_CHAVES-1:0] w_jogada;
  logic                w_um_bit;
  logic                w_tem_chave;

  assign w_tem_chave   = (chaves != '0);
  assign db_tem_jogada = w_tem_chave;
  assign w_um_bit      = (r_amostra != '0) &&
                         ((r_amostra & (r_amostra - W_CHAVES'(1))) == '0);

  // Next-state, sample, counter and play selection
  always_comb begin
    w_prox    = r_estado;
    w_amostra = r_amostra;
    w_cnt     = r_cnt;
    w_jogada  = jogada;
    case (r_estado)
      ESPERA: begin
        if (habilita && w_tem_chave) begin
          w_prox    = FILTRA;
          w_amostra = chaves;
          w_cnt     = '0;
        end
      end
      FILTRA: begin
        if (!habilita || !w_tem_chave) begin
          w_prox = ESPERA;
        end else if (chaves != r_amostra) begin
          w_amostra = chaves;
          w_cnt     = '0;
        end else if (r_cnt < CNT_MAX) begin
          w_cnt = r_cnt + W_CNT'(1);
        end else if (w_um_bit) begin
          w_prox   = PULSO;
          w_jogada = r_amostra;
        end else begin
          w_prox = INVALIDA;
        end
      end
      PULSO, INVALIDA: begin
        w_prox = SOLTA;
        w_cnt  = '0;
      end
      SOLTA: begin
        // Any key activity restarts the release filter; saturate instead of wrapping
        if (w_tem_chave) begin
          w_cnt = '0;
        end else if (r_cnt >= CNT_MAX) begin
          w_prox = ESPERA;
        end else begin
          w_cnt = r_cnt + W_CNT'(1);
        end
      end
      default: begin
        w_prox = ESPERA;
        w_cnt  = '0;
      end
    endcase
  end

  // State register; pulses and state code are registered from the next state
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado        <= ESPERA;
      r_amostra       <= '0;
      r_cnt           <= '0;
      jogada          <= '0;
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
      db_estado       <= '0;
    end else begin
      r_estado        <= w_prox;
      r_amostra       <= w_amostra;
      r_cnt           <= w_cnt;
      jogada          <= w_jogada;
      jogada_feita    <= (w_prox == PULSO);
      jogada_invalida <= (w_prox == INVALIDA);
      db_estado       <= W_ESTADO'(w_prox);
    end
  end

endmodule

// File: tb/tb_detector_jogada.sv
// Randomised bench for detector_jogada: an event-level model predicts when each accepted or
// rejected play must appear; a monitor matches DUT pulses against that expectation queue.
module tb_detector_jogada;

  localparam int unsigned D = 4;

  logic       clock;
  logic       reset;
  logic [3:0] chaves;
  logic       habilita;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       jogada_invalida;
  logic [3:0] db_estado;
  logic       db_tem_jogada;

  detector_jogada #(.DEBOUNCE_CYCLES(D)) dut (
    .clock          (clock),
    .reset          (reset),
    .chaves         (chaves),
    .habilita       (habilita),
    .jogada_feita   (jogada_feita),
    .jogada         (jogada),
    .jogada_invalida(jogada_invalida),
    .db_estado      (db_estado),
    .db_tem_jogada  (db_tem_jogada)
  );

  typedef struct {
    int unsigned edge_idx;
    bit          valid_play;
    logic [3:0]  code;
  } evt_t;

  evt_t        exp_q[$];
  evt_t        e;
  int unsigned edge_n = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;

  // Reference: lengths of stable runs rather than machine states
  int          run_len;
  int          quiet_len;
  bit          awaiting_release;
  bit          event_cycle;
  logic [3:0]  held_val;
  logic [3:0]  exp_jogada;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edge_n++;

  task automatic model(input logic rn, input logic h, input logic [3:0] c);
    if (!rn) begin
      run_len = 0; quiet_len = 0; awaiting_release = 0; event_cycle = 0;
      held_val = '0; exp_jogada = '0;
    end else if (event_cycle) begin
      event_cycle = 0; awaiting_release = 1; quiet_len = 0;
    end else if (awaiting_release) begin
      if (c == 4'b0) begin
        quiet_len++;
        if (quiet_len == int'(D)) awaiting_release = 0;
      end else quiet_len = 0;
    end else if (run_len == 0) begin
      if (h && c != 4'b0) begin run_len = 1; held_val = c; end
    end else if (!h || c == 4'b0) begin
      run_len = 0;
    end else if (c != held_val) begin
      held_val = c; run_len = 1;
    end else if (run_len < int'(D)) begin
      run_len++;
    end else begin
      // Press stable for D+1 sampled edges: one event, delivered right after this edge
      run_len = 0; event_cycle = 1;
      if ($countones(held_val) == 1) begin
        exp_jogada = held_val;
        exp_q.push_back('{edge_n + 1, 1'b1, held_val});
      end else begin
        exp_q.push_back('{edge_n + 1, 1'b0, held_val});
      end
    end
  endtask

  task automatic step(input logic rn, input logic h, input logic [3:0] c);
    #1;
    reset = rn; habilita = h; chaves = c;
    model(rn, h, c);
    @(negedge clock);
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, expv, $time);
    end
  endtask

  // Monitor: compares every presented pulse against the expectation queue
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (db_tem_jogada !== (|chaves)) begin
        errors++;
        $display("FAIL db_tem_jogada: got %b expected %b", db_tem_jogada, |chaves);
      end
      checks++;
      if (jogada !== exp_jogada) begin
        errors++;
        $display("FAIL jogada_hold: got %b expected %b (edge %0d)", jogada, exp_jogada, edge_n);
      end
      checks++;
      if (jogada_feita && jogada_invalida) begin
        errors++;
        $display("FAIL pulse_exclusive: feita=%b invalida=%b", jogada_feita, jogada_invalida);
      end
      if (jogada_feita || jogada_invalida) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: feita=%b invalida=%b expected none (edge %0d)",
                   jogada_feita, jogada_invalida, edge_n);
        end else begin
          e = exp_q.pop_front();
          if (e.edge_idx != edge_n || e.valid_play != jogada_feita ||
              (jogada_feita && jogada !== e.code)) begin
            errors++;
            $display("FAIL pulse_match: got edge %0d feita=%b jogada=%b expected edge %0d feita=%b jogada=%b",
                     edge_n, jogada_feita, jogada, e.edge_idx, e.valid_play, e.code);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].edge_idx <= edge_n) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL missed_pulse: got none expected feita=%b at edge %0d", e.valid_play, e.edge_idx);
      end
    end
  end

  int seq_est[6] = '{1, 1, 1, 1, 2, 4};

  initial begin
    reset = 1'b0; habilita = 1'b0; chaves = 4'b0;
    run_len = 0; quiet_len = 0; awaiting_release = 0; event_cycle = 0;
    held_val = '0; exp_jogada = '0;
    @(negedge clock);
    step(0, 1, 4'b0101);
    step(0, 0, 4'b0000);
    chk("reset_estado", int'(db_estado), 0);
    chk("reset_feita", int'(jogada_feita), 0);
    chk("reset_invalida", int'(jogada_invalida), 0);
    chk("reset_jogada", int'(jogada), 0);
    mon_en = 1;

    // Clean press: state codes 1,1,1,1,2,4
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 4'b0010);
      chk("press_estado", int'(db_estado), seq_est[i]);
      if (i == 4) chk("press_feita", int'(jogada_feita), 1);
    end
    chk("press_jogada", int'(jogada), 2);
    for (int i = 0; i < 4; i++) step(1, 1, 4'b0000);
    chk("release_estado", int'(db_estado), 0);

    // Short glitch discarded
    step(1, 1, 4'b0100); step(1, 1, 4'b0100); step(1, 1, 4'b0000);
    chk("glitch_estado", int'(db_estado), 0);

    // Multi-key press rejected
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 4'b0011);
      if (i == 4) chk("invalid_estado", int'(db_estado), 3);
    end
    for (int i = 0; i < 4; i++) step(1, 1, 4'b0000);
    chk("invalid_release", int'(db_estado), 0);

    // Held key, bouncy release, then second press
    for (int i = 0; i < 20; i++) step(1, 1, 4'b1000);
    step(1, 1, 4'b0000); step(1, 1, 4'b0000); step(1, 1, 4'b1000);
    for (int i = 0; i < 3; i++) step(1, 1, 4'b0000);
    chk("bounce_still_solta", int'(db_estado), 4);
    step(1, 1, 4'b0000);
    chk("bounce_espera", int'(db_estado), 0);
    for (int i = 0; i < 6; i++) step(1, 1, 4'b0001);
    chk("second_press_jogada", int'(jogada), 1);
    for (int i = 0; i < 4; i++) step(1, 1, 4'b0000);

    // habilita low: ignored in ESPERA, aborts FILTRA
    for (int i = 0; i < 3; i++) step(1, 0, 4'b0001);
    chk("disabled_estado", int'(db_estado), 0);
    chk("disabled_tem", int'(db_tem_jogada), 1);
    step(1, 1, 4'b0001); step(1, 1, 4'b0001);
    step(1, 0, 4'b0001);
    chk("abort_estado", int'(db_estado), 0);
    step(1, 0, 4'b0000);

    // Reset during the pulse cycle
    for (int i = 0; i < 5; i++) step(1, 1, 4'b1000);
    chk("pre_reset_estado", int'(db_estado), 2);
    step(0, 1, 4'b1000);
    chk("midpulse_estado", int'(db_estado), 0);
    chk("midpulse_jogada", int'(jogada), 0);
    chk("midpulse_feita", int'(jogada_feita), 0);
    step(1, 1, 4'b0000); step(1, 1, 4'b0000);

    // Randomised bursts
    for (int b = 0; b < 600; b++) begin
      logic [3:0] v;
      int unsigned kind = $urandom_range(0, 9);
      int unsigned len  = $urandom_range(1, 9);
      logic h = ($urandom_range(0, 19) != 0);
      if (kind < 5)      v = 4'(1 << $urandom_range(0, 3));
      else if (kind < 7) v = 4'($urandom_range(1, 15));
      else               v = 4'b0000;
      for (int k = 0; k < int'(len); k++) begin
        logic [3:0] cv = v;
        if ($urandom_range(0, 15) == 0) cv = 4'($urandom_range(0, 15));
        step(($urandom_range(0, 299) != 0), h, cv);
      end
    end
    for (int i = 0; i < 2 * int'(D) + 4; i++) step(1, 0, 4'b0000);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
DETECTOR_JOGADA -- requirements
Module: detector_jogada

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable clock cycles needed to accept a press or a release (legal range 1..255).
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clock.
REQ-004 SHALL have port chaves  input  4  raw player switch/button vector, one bit per colour.
REQ-005 SHALL have port habilita  input  1  high = new plays may start being detected.
REQ-006 SHALL have port jogada_feita  output  1  one-cycle pulse: a valid play was accepted.
REQ-007 SHALL have port jogada  output  4  registered one-hot code of the last accepted play.
REQ-008 SHALL have port jogada_invalida  output  1  one-cycle pulse: a stable non-one-hot press was rejected.
REQ-009 SHALL have port db_estado  output  4  current FSM state code.
REQ-010 SHALL have port db_tem_jogada  output  1  combinational OR of chaves.

Function
REQ-011 SHALL implement a Moore FSM with states and codes ESPERA=0, FILTRA=1, PULSO=2, INVALIDA=3, SOLTA=4; db_estado = state code, zero-extended to 4 bits.
REQ-012 SHALL keep an internal 4-bit sample register (amostra) and an 8-bit stability counter (cnt).
REQ-013 ESPERA: if habilita=1 and chaves!=0 -> FILTRA, amostra<=chaves, cnt<=0; else stay; chaves!=0 with habilita=0 is ignored.
REQ-014 FILTRA, chaves==0 -> ESPERA (glitch discarded, no pulse).
REQ-015 FILTRA, chaves!=0 and chaves!=amostra -> stay, amostra<=chaves, cnt<=0 (filter restarts).
REQ-016 FILTRA, chaves==amostra and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1.
REQ-017 FILTRA, chaves==amostra and cnt==DEBOUNCE_CYCLES-1 -> PULSO with jogada<=amostra if amostra has exactly one bit set; otherwise -> INVALIDA, jogada unchanged.
REQ-018 FILTRA, habilita=0 -> ESPERA, regardless of chaves (abort has priority over REQ-014..017).
REQ-019 PULSO: jogada_feita=1 for this single cycle; unconditional -> SOLTA, cnt<=0.
REQ-020 INVALIDA: jogada_invalida=1 for this single cycle; unconditional -> SOLTA, cnt<=0.
REQ-021 SOLTA: chaves!=0 -> cnt<=0; chaves==0 -> cnt<=cnt+1; chaves==0 and cnt==DEBOUNCE_CYCLES-1 -> ESPERA.
REQ-022 Latency: a press stable from the edge that leaves ESPERA asserts jogada_feita in the cycle after the DEBOUNCE_CYCLES-th following rising edge (DEBOUNCE_CYCLES+1 edges total).
REQ-023 jogada_feita and jogada_invalida SHALL never both be 1 and SHALL each be high for at most one consecutive cycle.
REQ-024 jogada SHALL hold its value until the next accepted play or reset; it changes on the same edge that enters PULSO.
REQ-025 A held key SHALL produce exactly one jogada_feita; a new play requires a full debounced release (SOLTA -> ESPERA).
REQ-026 Undefined state codes SHALL return to ESPERA on the next edge.
REQ-027 cnt SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap-around).

Reset
REQ-028 reset=0 at a rising edge SHALL force state=ESPERA, amostra=0, cnt=0, jogada=0000, with priority over every transition, including mid-FILTRA and mid-PULSO.
REQ-029 During and immediately after reset: jogada_feita=0, jogada_invalida=0, db_estado=0000; db_tem_jogada still follows chaves.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 reset released, habilita=1, chaves=0010 held from edge 0 -> jogada_feita=1 only in the cycle after edge 4, jogada=0010, db_estado 0->1->2->4.
REQ-031 chaves=0100 for 2 cycles then 0000 -> returns to ESPERA, no pulse, jogada unchanged.
REQ-032 chaves=0011 held 6 cycles -> jogada_invalida=1 for exactly one cycle, jogada_feita stays 0, jogada unchanged.
REQ-033 chaves=1000 held 20 cycles after acceptance -> single jogada_feita; release with 1-cycle bounce (0000,0000,1000,0000 x4) -> ESPERA only after 4 consecutive zero cycles; second press then accepted.
REQ-034 habilita=0 with chaves=0001 -> stays ESPERA, db_tem_jogada=1; habilita dropped mid-FILTRA -> ESPERA, no pulse.
REQ-035 reset=0 asserted in the PULSO cycle -> next cycle db_estado=0000, jogada=0000, jogada_feita=0.
